// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for serial_subtractor.
// Defining SERSUB_OVF_EN adds the signed-overflow flag ovf.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             busy;
  logic             done;
`ifdef SERSUB_OVF_EN
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  diff, bout, busy, done, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output diff, bout, busy, done, ovf
  );
`else
  modport master (
    output start, a, b, bin,
    input  diff, bout, busy, done
  );

  modport slave (
    input  start, a, b, bin,
    output diff, bout, busy, done
  );
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Digit-serial WIDTH-bit subtractor: diff = a - b - bin, DIGIT bits per clock, LSB digit first.
// Optional SERSUB_OVF_EN adds a signed two's-complement overflow flag (ovf) on the interface.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);

  localparam int N_DIG = WIDTH / DIGIT;
  localparam int CNT_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(N_DIG - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q,  a_sh_d;
  logic [WIDTH-1:0] b_sh_q,  b_sh_d;
  logic             brw_q,   brw_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] diff_q,  diff_d;
  logic             bout_q,  bout_d;
`ifdef SERSUB_OVF_EN
  logic             ovf_q,   ovf_d;
`endif

  logic             start_ok;
  logic [DIGIT:0]   dig_sub;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    brw_d   = brw_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
`ifdef SERSUB_OVF_EN
    ovf_d   = ovf_q;
`endif

    // One digit of the subtraction; the top bit is the borrow out of this digit.
    dig_sub  = {1'b0, a_sh_q[DIGIT-1:0]} - {1'b0, b_sh_q[DIGIT-1:0]}
             - {{DIGIT{1'b0}}, brw_q};
    start_ok = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_RUN;
      end
      S_RUN: begin
        a_sh_d = a_sh_q >> DIGIT;
        b_sh_d = b_sh_q >> DIGIT;
        brw_d  = dig_sub[DIGIT];
        bout_d = dig_sub[DIGIT];
        diff_d = (diff_q >> DIGIT) | (WIDTH'(dig_sub[DIGIT-1:0]) << (WIDTH - DIGIT));
        if (cnt_q == LAST_DIG) begin
          state_d = S_DONE;
`ifdef SERSUB_OVF_EN
          // In the last digit the low bits of the shift registers hold the operand MSBs.
          ovf_d = (a_sh_q[DIGIT-1] != b_sh_q[DIGIT-1]) &&
                  (dig_sub[DIGIT-1] != a_sh_q[DIGIT-1]);
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = bus.start ? S_RUN : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (start_ok) begin
      a_sh_d = bus.a;
      b_sh_d = bus.b;
      brw_d  = bus.bin;
      cnt_d  = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
`ifdef SERSUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      brw_q   <= brw_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
`ifdef SERSUB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.busy = (state_q == S_RUN);
  assign bus.done = (state_q == S_DONE);
`ifdef SERSUB_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (DIGIT=1 and DIGIT=4 instances) with a result scoreboard.
// Checks ovf as well when SERSUB_OVF_EN is defined.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8)) bus1 ();
  serial_subtractor_if #(.WIDTH(8)) bus4 ();

  serial_subtractor #(.WIDTH(8), .DIGIT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  serial_subtractor #(.WIDTH(8), .DIGIT(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  typedef struct packed {
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic bin);
    logic [8:0] r;
    exp_t       e;
    r      = {1'b0, a} - {1'b0, b} - {8'd0, bin};
    e.diff = r[7:0];
    e.bout = r[8];
    e.ovf  = (a[7] != b[7]) && (r[7] != a[7]);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic s, input logic [7:0] a, input logic [7:0] b,
                       input logic bin);
    if (sel) begin
      bus4.start = s; bus4.a = a; bus4.b = b; bus4.bin = bin;
    end else begin
      bus1.start = s; bus1.a = a; bus1.b = b; bus1.bin = bin;
    end
  endtask

  function automatic logic obs_done(input bit sel);
    return sel ? bus4.done : bus1.done;
  endfunction

  function automatic logic obs_busy(input bit sel);
    return sel ? bus4.busy : bus1.busy;
  endfunction

  task automatic compare_result(input bit sel, input string tag);
    exp_t e;
    check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_diff"}, 32'(sel ? bus4.diff : bus1.diff), 32'(e.diff));
      check({tag, "_bout"}, 32'(sel ? bus4.bout : bus1.bout), 32'(e.bout));
`ifdef SERSUB_OVF_EN
      check({tag, "_ovf"}, 32'(sel ? bus4.ovf : bus1.ovf), 32'(e.ovf));
`endif
    end
  endtask

  // Issue one op at #1 after a posedge, wait (bounded) for done, check latency and result.
  task automatic run_op(input bit sel, input logic [7:0] a, input logic [7:0] b, input logic bin,
                        input int exp_lat, input int exp_busy, input string tag);
    int cycles;
    int n_busy;
    bit got;
    bit overlap;
    cycles = 0; n_busy = 0; got = 1'b0; overlap = 1'b0;
    drive(sel, 1'b1, a, b, bin);
    sb.push_back(model(a, b, bin));
    while (!got && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
      if (cycles == 1) drive(sel, 1'b0, ~a, ~b, ~bin);
      if (obs_busy(sel) && obs_done(sel)) overlap = 1'b1;
      if (obs_busy(sel)) n_busy++;
      if (obs_done(sel)) got = 1'b1;
    end
    check({tag, "_latency"}, 32'(cycles), 32'(exp_lat));
    check({tag, "_busy_cycles"}, 32'(n_busy), 32'(exp_busy));
    check({tag, "_busy_done_excl"}, 32'(overlap), 32'd0);
    if (got) compare_result(sel, tag);
    else if (sb.size() != 0) void'(sb.pop_front());
  endtask

  initial begin
    int dn;
    int first;
    int second;
    logic [7:0] ra, rb;
    logic       rbin;

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    drive(1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
    #12;
    check("rst_diff", 32'(bus1.diff), 32'd0);
    check("rst_bout", 32'(bus1.bout), 32'd0);
    check("rst_busy", 32'(bus1.busy), 32'd0);
    check("rst_done", 32'(bus1.done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic op, latency 9, busy 8; result held and done drops afterwards.
    run_op(1'b0, 8'd200, 8'd55, 1'b0, 9, 8, "t1");
    @(posedge clk); #1;
    check("t1_done_pulse", 32'(bus1.done), 32'd0);
    check("t1_diff_held", 32'(bus1.diff), 32'd145);

    run_op(1'b0, 8'd5, 8'd10, 1'b0, 9, 8, "t2_neg");
    run_op(1'b0, 8'd0, 8'd0, 1'b1, 9, 8, "t2_wrap");

    // Start during RUN cycle 3 must be ignored.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 8'd100, 8'd30, 1'b0);
    sb.push_back(model(8'd100, 8'd30, 1'b0));
    dn = 0;
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk); #1;
      if (c == 1) drive(1'b0, 1'b0, 8'd100, 8'd30, 1'b0);
      if (c == 3) drive(1'b0, 1'b1, 8'd1, 8'd1, 1'b0);
      if (c == 4) drive(1'b0, 1'b0, 8'd1, 8'd1, 1'b0);
      if (bus1.done) begin
        dn++;
        compare_result(1'b0, "t3");
      end
    end
    check("t3_done_count", 32'(dn), 32'd1);
    sb.delete();

    // Start held through DONE: second op accepted in the DONE cycle.
    drive(1'b0, 1'b1, 8'd50, 8'd20, 1'b0);
    sb.push_back(model(8'd50, 8'd20, 1'b0));
    dn = 0; first = 0; second = 0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        drive(1'b0, 1'b1, 8'd77, 8'd33, 1'b1);
        sb.push_back(model(8'd77, 8'd33, 1'b1));
      end
      if (dn == 1 && c == first + 1) drive(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
      if (bus1.done) begin
        dn++;
        if (dn == 1) first = c;
        else if (dn == 2) second = c;
        compare_result(1'b0, "t4");
      end
    end
    check("t4_done_count", 32'(dn), 32'd2);
    check("t4_spacing", 32'(second - first), 32'd9);
    sb.delete();

    // Reset in RUN cycle 4: outputs clear at once and no done follows.
    drive(1'b0, 1'b1, 8'hAA, 8'h11, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      if (c == 1) drive(1'b0, 1'b0, 8'hAA, 8'h11, 1'b0);
    end
    #2 rst_n = 1'b0;
    #1;
    check("t5_diff", 32'(bus1.diff), 32'd0);
    check("t5_bout", 32'(bus1.bout), 32'd0);
    check("t5_busy", 32'(bus1.busy), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (bus1.done) dn++;
    end
    check("t5_no_done", 32'(dn), 32'd0);
    run_op(1'b0, 8'd9, 8'd3, 1'b0, 9, 8, "t5_after");

    for (int i = 0; i < 6; i++) begin
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      rbin = 1'($urandom);
      run_op(1'b0, ra, rb, rbin, 9, 8, "rand");
    end

    // DIGIT=4 instance: two digit cycles, done 3 clocks after start.
    @(posedge clk); #1;
    run_op(1'b1, 8'h80, 8'h01, 1'b0, 3, 2, "t6_ovf");
    run_op(1'b1, 8'h10, 8'h01, 1'b0, 3, 2, "t6_noovf");
    run_op(1'b1, 8'h00, 8'h01, 1'b1, 3, 2, "t6_wrap");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
